// File: rtl/minimization_mu_bw16.sv
// minimization_mu_bw16: mu operator, finds least y in 0..MAXY with child g(x, y) == 0.
module minimization_mu_bw16 #(
  parameter int BW = 16,
  parameter logic [BW-1:0] MAXY = {BW{1'b1}}
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  input  logic [BW-1:0] IN0,
  output logic          RD,
  output logic [BW-1:0] RES,
  output logic          FAIL,
  output logic          G_ST,
  output logic [BW-1:0] G_X,
  output logic [BW-1:0] G_Y,
  input  logic          G_RD,
  input  logic [BW-1:0] G_RES
);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t state;
  logic st_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      st_q <= 1'b0;
      RD <= 1'b1;
      RES <= '0;
      FAIL <= 1'b0;
      G_ST <= 1'b0;
      G_X <= '0;
      G_Y <= '0;
    end else begin
      st_q <= ST;
      case (state)
        IDLE: if (ST && !st_q) begin
          G_X <= IN0;
          G_Y <= '0;
          G_ST <= 1'b1;
          RD <= 1'b0;
          FAIL <= 1'b0;
          state <= ACK;
        end
        ACK: if (!G_RD) begin
          G_ST <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (G_RD) begin
          if (G_RES == '0) begin
            RES <= G_Y;
            FAIL <= 1'b0;
            RD <= 1'b1;
            state <= IDLE;
          end else if (G_Y == MAXY) begin
            RES <= MAXY;
            FAIL <= 1'b1;
            RD <= 1'b1;
            state <= IDLE;
          end else begin
            G_Y <= G_Y + 1'b1;
            G_ST <= 1'b1;
            state <= ACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/minimization_mu_bw16.md
# minimization_mu_bw16

Minimization (mu) operator for the recursive-function datapath. On a start request it computes the least y in 0..MAXY such that the child function g(x, y) returns 0. It is the initiating end of the ST/RD start/ready handshake: it drives a child block's ST, waits for that child's RD, and captures the child's RES. Upward it exposes the standard ST/RD/RES responder interface, so it composes with composition and primitive-recursion blocks.

## Interface
- BW, 16: data width of x, y and results
- MAXY, 2**BW-1: largest y tried before reporting failure
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- ST  in  1  start request; the rising edge (0 in previous sample, 1 now) starts a search
- IN0  in  BW  argument x; sampled on the ST rising edge
- RD  out  1  ready; 1 = idle or result valid, 0 = search in progress
- RES  out  BW  least y with g(x, y)=0, or MAXY on failure
- FAIL  out  1  1 = no zero found in 0..MAXY; valid when RD=1
- G_ST  out  1  start to child g
- G_X  out  BW  x operand to child, stable throughout a call
- G_Y  out  BW  y operand to child, stable throughout a call
- G_RD  in  1  child ready
- G_RES  in  BW  child result; valid when G_RD=1

## Operation
- All outputs are registered.
- Reset values: RD=1, RES=0, FAIL=0, G_ST=0, G_X=0, G_Y=0, state IDLE, ST history 0.
- Reset is asynchronous. Asserting it mid-search aborts the search immediately and forces G_ST=0. The child is reset by its own reset, not by this block.
- **IDLE**
  - On the ST rising edge: G_X<=IN0, G_Y<=0, G_ST<=1, RD<=0, FAIL<=0, then go to ACK.
  - RES keeps its previous value until the new search finishes.
- **ACK**
  - Hold G_ST=1 until G_RD is sampled 0.
  - On sampling G_RD=0: G_ST<=0, then go to WAIT.
  - If the child never drops G_RD, the block waits indefinitely; there is no timeout.
- **WAIT**
  - Wait for G_RD sampled 1. That edge is the evaluation edge.
  - If G_RES==0: RES<=G_Y, FAIL<=0, RD<=1, then go to IDLE.
  - Else if G_Y==MAXY: RES<=MAXY, FAIL<=1, RD<=1, then go to IDLE.
  - Else: G_Y<=G_Y+1, G_ST<=1, then go to ACK.
- G_Y never wraps: the MAXY check precedes the increment. MAXY=2**BW-1 with no zero found gives RES=all-ones, FAIL=1.
- G_ST is low for at least one sampled edge between consecutive calls, so the child always sees a fresh rising edge.
- ST rising edges while RD=0 are ignored. A held ST does not restart the search; a new rising edge is required.
- The ST history register updates every cycle in every state.

## Timing
- Edge 0 samples the ST rising edge. G_ST=1 after edge 0.
- Child latency L ≥ 1 is defined as follows:
  - the child samples G_ST at edge 1 and drops G_RD after edge 1;
  - it raises G_RD after edge 1+L.
- Iteration k (0-based) evaluates at edge (k+1)(L+2). The iteration period is L+2 cycles.
- For a first zero at y=n, RD rises after edge (n+1)(L+2), with RES and FAIL valid in the same cycle.
- Failure makes RD rise after edge (MAXY+1)(L+2).
- A new ST rising edge is accepted at the earliest one edge after RD rises.

## Test plan
All scenarios use a behavioral child g(x, y) = (x>y) ? x−y : 0 with L=3 (period 5).
- IN0=5, ST pulse at edge 0:
  - G_Y steps 0..5;
  - RD rises after edge 30 with RES=5, FAIL=0;
  - G_ST sees exactly 6 rising edges.
- IN0=0: RD rises after edge 5 with RES=0, FAIL=0. Only one child call is made.
- MAXY=3, IN0=10: RD rises after edge 20 with RES=3, FAIL=1. G_Y never exceeds 3.
- IN0=4 with ST held high for 40 cycles, plus an extra ST pulse at edge 8:
  - the search is not restarted;
  - RES=4 after edge 25;
  - no second search starts until ST falls and rises again.
- IN0=7, RST driven low asynchronously mid-cycle at cycle 12:
  - RD=1, G_ST=0, RES=0, FAIL=0 immediately, without waiting for a clock edge;
  - after release, a new search with IN0=2 returns RES=2 after edge 15.
- Child with L=1 and IN0=3: RD rises after edge 12 with RES=3. This confirms the minimum-latency handshake is not missed.
